// File: rtl/dvi_tmds_pkg.sv
// Shared types, control tokens and stage-1 helpers for the DVI TMDS encoder.
// Contents:
//   tmds_sym_t           - one 10-bit TMDS symbol, bit 0 transmitted first
//   tmds_disp_t          - signed running-disparity count
//   CTL_TOKEN_00..11     - blanking tokens indexed by {C1, C0}
//   popcount8()          - number of ones in a byte
//   minimize_transitions - 8-bit data to 9-bit transition-minimised q_m
//   ctl_token()          - {C1, C0} to control token
package dvi_tmds_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] tmds_disp_t;

    localparam tmds_sym_t CTL_TOKEN_00 = 10'b1101010100;
    localparam tmds_sym_t CTL_TOKEN_01 = 10'b0010101011;
    localparam tmds_sym_t CTL_TOKEN_10 = 10'b0101010100;
    localparam tmds_sym_t CTL_TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // XNOR chaining is chosen for ones-heavy bytes, and for exactly four ones
    // when D[0] is 0. q_m[8] records which chain was used: 1 = XOR, 0 = XNOR.
    function automatic logic [8:0] minimize_transitions(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic tmds_sym_t ctl_token(input logic [1:0] c);
        tmds_sym_t t;
        unique case (c)
            2'b00:   t = CTL_TOKEN_00;
            2'b01:   t = CTL_TOKEN_01;
            2'b10:   t = CTL_TOKEN_10;
            default: t = CTL_TOKEN_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: two-stage 8b/10b encoder with its own running disparity.
// Ports:
//   clk   - pixel clock
//   rst   - synchronous, active-high reset
//   data  - pixel byte, used when de = 1
//   de    - active video; 0 sends the control token selected by ctl
//   ctl   - {C1, C0} for blanking
//   sym   - encoded symbol, two cycles after its inputs
module tmds_channel_enc
    import dvi_tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       de,
    input  logic [1:0] ctl,
    output tmds_sym_t  sym
);

    // Stage 1: transition minimisation.
    logic [8:0] q_m;
    logic       de_s1;
    logic [1:0] ctl_s1;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_m    <= '0;
            de_s1  <= 1'b0;
            ctl_s1 <= 2'b00;
        end else begin
            q_m    <= minimize_transitions(data);
            de_s1  <= de;
            ctl_s1 <= ctl;
        end
    end

    // Stage 2: DC balancing against the running disparity.
    tmds_disp_t cnt;
    tmds_disp_t cnt_next;
    tmds_disp_t diff;
    tmds_sym_t  sym_next;
    logic [3:0] n1;
    logic [3:0] n0;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        sym_next = CTL_TOKEN_00;
        cnt_next = '0;
        n1       = popcount8(q_m[7:0]);
        n0       = 4'd8 - n1;
        // n1 - n0 as a signed quantity; both counts are zero-extended first.
        diff     = $signed({1'b0, n1}) - $signed({1'b0, n0});

        if (!de_s1) begin
            // Blanking always restarts the disparity from zero.
            sym_next = ctl_token(ctl_s1);
            cnt_next = '0;
        end else if ((cnt == '0) || (n1 == n0)) begin
            sym_next = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
            cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            // Disparity and the byte lean the same way: send it inverted.
            sym_next = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            sym_next = {1'b0, q_m[8], q_m[7:0]};
            cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym <= CTL_TOKEN_00;
            cnt <= '0;
        end else begin
            sym <= sym_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: RGB + sync + data enable to three 10-bit symbols per
// pixel, fixed two-cycle latency, no stall.
// Parameters:
//   HSYNC_INV - invert hsync_i before it becomes C0 on channel 0
//   VSYNC_INV - invert vsync_i before it becomes C1 on channel 0
// Ports:
//   clk_i, rst_i               - pixel clock, synchronous active-high reset
//   red_i, green_i, blue_i     - pixel colour, used when de_i = 1
//   hsync_i, vsync_i           - syncs from the timing generator
//   de_i                       - active video enable
//   tmds_ch0_o/ch1_o/ch2_o     - blue/green/red symbols, bit 0 sent first
//   de_o                       - de_i aligned with the symbols
module dvi_tmds_encoder
    import dvi_tmds_pkg::*;
#(
    parameter bit HSYNC_INV = 1'b0,
    parameter bit VSYNC_INV = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       de_i,
    output logic [9:0] tmds_ch0_o,
    output logic [9:0] tmds_ch1_o,
    output logic [9:0] tmds_ch2_o,
    output logic       de_o
);

    // Syncs ride on channel 0 only; the other channels carry C1C0 = 00.
    logic [1:0] ctl_ch0;
    assign ctl_ch0 = {vsync_i ^ VSYNC_INV, hsync_i ^ HSYNC_INV};

    tmds_channel_enc u_ch0 (
        .clk  (clk_i),
        .rst  (rst_i),
        .data (blue_i),
        .de   (de_i),
        .ctl  (ctl_ch0),
        .sym  (tmds_ch0_o)
    );

    tmds_channel_enc u_ch1 (
        .clk  (clk_i),
        .rst  (rst_i),
        .data (green_i),
        .de   (de_i),
        .ctl  (2'b00),
        .sym  (tmds_ch1_o)
    );

    tmds_channel_enc u_ch2 (
        .clk  (clk_i),
        .rst  (rst_i),
        .data (red_i),
        .de   (de_i),
        .ctl  (2'b00),
        .sym  (tmds_ch2_o)
    );

    // Two registers to match the encoder pipeline depth.
    logic de_d1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_d1 <= 1'b0;
            de_o  <= 1'b0;
        end else begin
            de_d1 <= de_i;
            de_o  <= de_d1;
        end
    end

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed-vector bench for dvi_tmds_encoder with a scoreboard queue: the
// stimulus pushes hand-computed symbols tagged with the cycle they are due,
// and a monitor on the falling edge pops and compares them.
module tb_dvi_tmds_encoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] red_i, green_i, blue_i;
    logic       hsync_i, vsync_i, de_i;
    logic [9:0] tmds_ch0_o, tmds_ch1_o, tmds_ch2_o;
    logic       de_o;

    dvi_tmds_encoder #(
        .HSYNC_INV (1'b0),
        .VSYNC_INV (1'b0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .red_i      (red_i),
        .green_i    (green_i),
        .blue_i     (blue_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .de_i       (de_i),
        .tmds_ch0_o (tmds_ch0_o),
        .tmds_ch1_o (tmds_ch1_o),
        .tmds_ch2_o (tmds_ch2_o),
        .de_o       (de_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
        logic       ede;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_compared = 0;
    int   n_mismatch = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop every entry that is due now and compare it.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            if (cur.due < cyc) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL %s: entry due at %0d not checked, now %0d", cur.tag, cur.due, cyc);
            end else begin
                check({cur.tag, " ch0"}, tmds_ch0_o, cur.e0);
                check({cur.tag, " ch1"}, tmds_ch1_o, cur.e1);
                check({cur.tag, " ch2"}, tmds_ch2_o, cur.e2);
                check({cur.tag, " de_o"}, {9'd0, de_o}, {9'd0, cur.ede});
            end
        end
    end

    // Apply one cycle of inputs. Data/control appear 2 cycles later; a reset
    // shows on the very next edge.
    task automatic drive(input string tag, input bit rst, input bit de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input bit hs, input bit vs, input bit chk,
                         input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                         input bit ede);
        exp_t x;
        @(posedge clk_i);
        #1;
        rst_i   = rst;
        de_i    = de;
        red_i   = r;
        green_i = g;
        blue_i  = b;
        hsync_i = hs;
        vsync_i = vs;
        if (chk) begin
            x.due = cyc + (rst ? 1 : 2);
            x.e0  = e0;
            x.e1  = e1;
            x.e2  = e2;
            x.ede = ede;
            x.tag = tag;
            sb.push_back(x);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        de_i    = 1'b0;
        red_i   = '0;
        green_i = '0;
        blue_i  = '0;
        hsync_i = 1'b0;
        vsync_i = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            drive("reset_hold", 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'b1, 10'h354, 10'h354, 10'h354, 1'b0);
        end
        drive("release", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);

        // Control tokens.
        drive("ctl_h",   0, 0, 8'hAA, 8'h55, 8'h12, 1, 0, 1, 10'h0AB, 10'h354, 10'h354, 0);
        drive("ctl_hv",  0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 10'h2AB, 10'h354, 10'h354, 0);
        drive("ctl_v",   0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 10'h154, 10'h354, 10'h354, 0);

        // Disparity sequence on 8'h00: cnt 0 -> -8 -> +2 -> -6.
        drive("zero_1",  0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h100, 10'h100, 10'h100, 1);
        drive("zero_2",  0, 1, 8'h00, 8'h00, 8'h00, 1, 1, 1, 10'h3FF, 10'h3FF, 10'h3FF, 1);
        drive("zero_3",  0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h100, 10'h100, 10'h100, 1);

        // XNOR path, and a single blanking cycle restarts the disparity.
        drive("blank_a", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);
        drive("ff_1",    0, 1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 10'h200, 10'h200, 10'h200, 1);
        drive("blank_b", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);
        drive("ff_2",    0, 1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 10'h200, 10'h200, 10'h200, 1);
        drive("blank_c", 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);

        // Independent channels. blue 1E (n1d=4, D0=0 -> XNOR), green 0F
        // (n1d=4, D0=1 -> XOR), red 10 (balanced q_m, cnt stays 0).
        // ch0 cnt 0 -> +4 -> -2 -> +2; ch1 cnt 0 -> -4 -> +2 -> -2.
        drive("mix_1",   0, 1, 8'h10, 8'h0F, 8'h1E, 0, 0, 1, 10'h25F, 10'h105, 10'h1F0, 1);
        drive("mix_2",   0, 1, 8'h10, 8'h0F, 8'h1E, 0, 0, 1, 10'h0A0, 10'h3FA, 10'h1F0, 1);
        drive("mix_3",   0, 1, 8'h10, 8'h0F, 8'h1E, 0, 0, 1, 10'h25F, 10'h105, 10'h1F0, 1);

        // Mid-line reset with cnt != 0: the pixel in flight is discarded.
        drive("pre_rst", 0, 1, 8'h10, 8'h0F, 8'h1E, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);
        drive("mid_rst", 1, 1, 8'h33, 8'hC4, 8'h7E, 1, 1, 1, 10'h354, 10'h354, 10'h354, 0);
        drive("post_1",  0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h100, 10'h100, 10'h100, 1);
        drive("post_2",  0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h3FF, 10'h3FF, 10'h3FF, 1);
        drive("tail",    0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h354, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk_i);
        end
        @(negedge clk_i);
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
